// File: rtl/gemm_ctrl_pkg.sv
// gemm_ctrl_pkg: shared state encoding and default widths for the GEMM tile sequencer
package gemm_ctrl_pkg;
    localparam int DEF_DIM_WIDTH  = 8;
    localparam int DEF_ADDR_WIDTH = 16;
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FETCH,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } ctrl_state_e;
endpackage

// File: rtl/tile_addr_gen.sv
// tile_addr_gen: m/n/k tile counters with running address bases (no multipliers)
module tile_addr_gen
    import gemm_ctrl_pkg::*;
#(
    parameter int DimWidth  = DEF_DIM_WIDTH,
    parameter int AddrWidth = DEF_ADDR_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 step_k_i,
    input  logic                 step_n_i,
    input  logic [DimWidth-1:0]  m_tiles_i,
    input  logic [DimWidth-1:0]  k_tiles_i,
    input  logic [DimWidth-1:0]  n_tiles_i,
    output logic [AddrWidth-1:0] a_addr_o,
    output logic [AddrWidth-1:0] b_addr_o,
    output logic [AddrWidth-1:0] c_addr_o,
    output logic                 first_k_o,
    output logic                 last_k_o,
    output logic                 last_n_o,
    output logic                 last_m_o
);
    localparam int PadW = AddrWidth - DimWidth;
    logic [DimWidth-1:0]  r_m, r_n, r_k;
    logic [AddrWidth-1:0] r_a_base, r_b_base, r_c_base;
    logic [AddrWidth-1:0] w_k, w_n, w_k_t, w_n_t;
    assign w_k   = {{PadW{1'b0}}, r_k};
    assign w_n   = {{PadW{1'b0}}, r_n};
    assign w_k_t = {{PadW{1'b0}}, k_tiles_i};
    assign w_n_t = {{PadW{1'b0}}, n_tiles_i};
    // a_base tracks m*K_t, b_base tracks k*N_t, c_base tracks m*N_t
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_m      <= '0;
            r_n      <= '0;
            r_k      <= '0;
            r_a_base <= '0;
            r_b_base <= '0;
            r_c_base <= '0;
        end else begin
            if (step_k_i) begin
                r_k      <= last_k_o ? '0 : r_k + DimWidth'(1);
                r_b_base <= last_k_o ? '0 : r_b_base + w_n_t;
            end
            if (step_n_i) begin
                r_n <= last_n_o ? '0 : r_n + DimWidth'(1);
                if (last_n_o) begin
                    r_m      <= r_m + DimWidth'(1);
                    r_a_base <= r_a_base + w_k_t;
                    r_c_base <= r_c_base + w_n_t;
                end
            end
        end
    end
    // addresses and wrap flags straight from the counters
    always_comb begin
        a_addr_o  = r_a_base + w_k;
        b_addr_o  = r_b_base + w_n;
        c_addr_o  = r_c_base + w_n;
        first_k_o = r_k == '0;
        last_k_o  = r_k == k_tiles_i - DimWidth'(1);
        last_n_o  = r_n == n_tiles_i - DimWidth'(1);
        last_m_o  = r_m == m_tiles_i - DimWidth'(1);
    end
endmodule

// File: rtl/gemm_tile_ctrl.sv
// gemm_tile_ctrl: sequences operand fetch, PE strobes and C-tile writeback over an MxN tile grid
module gemm_tile_ctrl
    import gemm_ctrl_pkg::*;
#(
    parameter int DimWidth  = DEF_DIM_WIDTH,
    parameter int AddrWidth = DEF_ADDR_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [DimWidth-1:0]  m_tiles_i,
    input  logic [DimWidth-1:0]  k_tiles_i,
    input  logic [DimWidth-1:0]  n_tiles_i,
    output logic [AddrWidth-1:0] a_addr_o,
    output logic [AddrWidth-1:0] b_addr_o,
    output logic                 ab_ren_o,
    output logic                 a_valid_o,
    output logic                 b_valid_o,
    output logic                 init_save_o,
    output logic                 acc_clr_o,
    output logic [AddrWidth-1:0] c_addr_o,
    output logic                 c_valid_o,
    input  logic                 c_ready_i,
    output logic                 busy_o,
    output logic                 done_o
);
    ctrl_state_e          r_state, w_next;
    logic [DimWidth-1:0]  r_m_t, r_k_t, r_n_t;
    logic                 r_beat, r_init;
    logic                 w_any_zero, w_accept, w_hs;
    logic                 w_first_k, w_last_k, w_last_n, w_last_m;
    logic [AddrWidth-1:0] w_a_addr, w_b_addr, w_c_addr;
    assign w_any_zero = (m_tiles_i == '0) || (k_tiles_i == '0) || (n_tiles_i == '0);
    assign w_accept   = (r_state == S_IDLE) && start_i && !w_any_zero;
    assign w_hs       = (r_state == S_WRITE) && c_ready_i;
    tile_addr_gen #(
        .DimWidth (DimWidth),
        .AddrWidth(AddrWidth)
    ) u_addr (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (w_accept),
        .step_k_i (r_state == S_FETCH),
        .step_n_i (w_hs),
        .m_tiles_i(r_m_t),
        .k_tiles_i(r_k_t),
        .n_tiles_i(r_n_t),
        .a_addr_o (w_a_addr),
        .b_addr_o (w_b_addr),
        .c_addr_o (w_c_addr),
        .first_k_o(w_first_k),
        .last_k_o (w_last_k),
        .last_n_o (w_last_n),
        .last_m_o (w_last_m)
    );
    // state register
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else r_state <= w_next;
    end
    // job dimensions only change on an accepted start
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_m_t <= '0;
            r_k_t <= '0;
            r_n_t <= '0;
        end else if (w_accept) begin
            r_m_t <= m_tiles_i;
            r_k_t <= k_tiles_i;
            r_n_t <= n_tiles_i;
        end
    end
    // SRAM read latency: data beat and init flag trail the read enable by one cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_beat <= 1'b0;
            r_init <= 1'b0;
        end else begin
            r_beat <= r_state == S_FETCH;
            r_init <= (r_state == S_FETCH) && w_first_k;
        end
    end
    // next-state: one accumulator set, so a tile's writeback finishes before the next fetch
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  w_next = start_i ? (w_any_zero ? S_DONE : S_CLR) : S_IDLE;
            S_CLR:   w_next = S_FETCH;
            S_FETCH: w_next = w_last_k ? S_DRAIN : S_FETCH;
            S_DRAIN: w_next = S_WRITE;
            S_WRITE: w_next = w_hs ? ((w_last_m && w_last_n) ? S_DONE : S_FETCH) : S_WRITE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end
    // output decode; addresses are zero outside the phase that uses them
    always_comb begin
        ab_ren_o    = r_state == S_FETCH;
        acc_clr_o   = r_state == S_CLR;
        c_valid_o   = r_state == S_WRITE;
        done_o      = r_state == S_DONE;
        busy_o      = r_state inside {S_CLR, S_FETCH, S_DRAIN, S_WRITE};
        a_valid_o   = r_beat;
        b_valid_o   = r_beat;
        init_save_o = r_init;
        a_addr_o    = (r_state == S_FETCH) ? w_a_addr : '0;
        b_addr_o    = (r_state == S_FETCH) ? w_b_addr : '0;
        c_addr_o    = (r_state == S_WRITE) ? w_c_addr : '0;
    end
endmodule

// File: tb/tb_gemm_tile_ctrl.sv
// tb_gemm_tile_ctrl: timeline model plus SRAM/PE model checking the GEMM tile sequencer
module tb_gemm_tile_ctrl;
    localparam int DW = 8;
    localparam int AW = 16;
    localparam int SQ = 2;
    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic          c_ready_i = 1'b0;
    logic [DW-1:0] m_tiles_i = '0, k_tiles_i = '0, n_tiles_i = '0;
    logic [AW-1:0] a_addr_o, b_addr_o, c_addr_o;
    logic          ab_ren_o, a_valid_o, b_valid_o, init_save_o, acc_clr_o;
    logic          c_valid_o, busy_o, done_o;
    int            vectors = 0;
    int            miscompares = 0;

    always #5 clk_i = ~clk_i;

    gemm_tile_ctrl #(.DimWidth(DW), .AddrWidth(AW)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .m_tiles_i  (m_tiles_i),
        .k_tiles_i  (k_tiles_i),
        .n_tiles_i  (n_tiles_i),
        .a_addr_o   (a_addr_o),
        .b_addr_o   (b_addr_o),
        .ab_ren_o   (ab_ren_o),
        .a_valid_o  (a_valid_o),
        .b_valid_o  (b_valid_o),
        .init_save_o(init_save_o),
        .acc_clr_o  (acc_clr_o),
        .c_addr_o   (c_addr_o),
        .c_valid_o  (c_valid_o),
        .c_ready_i  (c_ready_i),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    function automatic int a_el(int i, int j);
        return i + j + 1;
    endfunction

    function automatic int b_el(int i, int j);
        return i * j + 1;
    endfunction

    // Runs one job from a start at cycle 0. mode: 0 ready always, 1 random ready,
    // 2 ready withheld for the first 3 cycles of each c_valid. restart_at: cycle of a stray 1x1x1 start.
    task automatic run_job(input int mt, input int kt, input int nt, input int mode,
                           input int restart_at, input string name);
        int tiles, t, fs, done_cyc, k, rd_a, rd_b, tm, tk, tk2, tn, gm, gn, sum;
        int acc[SQ][SQ];
        int prod[SQ][SQ];
        bit prev_ren, prev_k0, ren, cv, busy, ready, ok, tile_ok;
        logic [7:0] exp_s, obs_s;
        tiles = (mt * kt * nt == 0) ? 0 : mt * nt;
        t = 0;
        fs = 2;
        done_cyc = (tiles == 0) ? 1 : -1;
        prev_ren = 0;
        prev_k0 = 0;
        rd_a = 0;
        rd_b = 0;
        ok = 0;
        for (int i = 0; i < SQ; i++)
            for (int j = 0; j < SQ; j++) acc[i][j] = 0;
        @(negedge clk_i);
        m_tiles_i = DW'(mt);
        k_tiles_i = DW'(kt);
        n_tiles_i = DW'(nt);
        start_i = 1'b1;
        c_ready_i = 1'b1;
        for (int cyc = 1; cyc < 3000; cyc++) begin
            @(negedge clk_i);
            ren  = tiles > 0 && t < tiles && cyc >= fs && cyc < fs + kt;
            cv   = tiles > 0 && t < tiles && cyc >= fs + kt + 1;
            k    = cyc - fs;
            busy = (done_cyc < 0) || (cyc < done_cyc);
            exp_s = {ren, prev_ren, prev_ren, prev_k0, cyc == 1 && tiles > 0, cv, busy, cyc == done_cyc};
            obs_s = {ab_ren_o, a_valid_o, b_valid_o, init_save_o, acc_clr_o, c_valid_o, busy_o, done_o};
            vectors++;
            if (obs_s !== exp_s) begin
                miscompares++;
                $display("FAIL %s strobes cyc=%0d ren/av/bv/init/clr/cv/busy/done got=%b exp=%b",
                         name, cyc, obs_s, exp_s);
            end
            if (ren) begin
                vectors++;
                if ({a_addr_o, b_addr_o} !== {AW'((t / nt) * kt + k), AW'(k * nt + t % nt)}) begin
                    miscompares++;
                    $display("FAIL %s ab_addr cyc=%0d got a=%0d b=%0d exp a=%0d b=%0d", name, cyc,
                             a_addr_o, b_addr_o, (t / nt) * kt + k, k * nt + t % nt);
                end
            end
            if (cv) begin
                vectors++;
                if (c_addr_o !== AW'(t)) begin
                    miscompares++;
                    $display("FAIL %s c_addr cyc=%0d got=%0d exp=%0d", name, cyc, c_addr_o, t);
                end
            end
            if (tiles > 0 && acc_clr_o === 1'b1)
                for (int i = 0; i < SQ; i++)
                    for (int j = 0; j < SQ; j++) acc[i][j] = 0;
            if (tiles > 0 && a_valid_o === 1'b1 && b_valid_o === 1'b1) begin
                tm = rd_a / kt;
                tk = rd_a % kt;
                tk2 = rd_b / nt;
                tn = rd_b % nt;
                for (int i = 0; i < SQ; i++)
                    for (int j = 0; j < SQ; j++) begin
                        prod[i][j] = 0;
                        for (int e = 0; e < SQ; e++)
                            prod[i][j] += a_el(tm * SQ + i, tk * SQ + e) * b_el(tk2 * SQ + e, tn * SQ + j);
                        acc[i][j] = (init_save_o === 1'b1) ? prod[i][j] : acc[i][j] + prod[i][j];
                    end
            end
            if (ab_ren_o === 1'b1) begin
                rd_a = int'(a_addr_o);
                rd_b = int'(b_addr_o);
            end
            prev_ren = ren;
            prev_k0 = ren && k == 0;
            start_i = (cyc == restart_at);
            if (cyc == restart_at) begin
                m_tiles_i = 1;
                k_tiles_i = 1;
                n_tiles_i = 1;
            end
            ready = (mode == 0) ? 1'b1 :
                    (mode == 1) ? ($urandom_range(0, 99) >= 50) :
                    (!cv || (cyc - (fs + kt + 1)) >= 3);
            c_ready_i = ready;
            if (cv && ready) begin
                gm = t / nt;
                gn = t % nt;
                tile_ok = 1;
                for (int i = 0; i < SQ; i++)
                    for (int j = 0; j < SQ; j++) begin
                        sum = 0;
                        for (int e = 0; e < kt * SQ; e++) sum += a_el(gm * SQ + i, e) * b_el(e, gn * SQ + j);
                        if (acc[i][j] != sum) begin
                            tile_ok = 0;
                            $display("FAIL %s c_tile t=%0d [%0d][%0d] got=%0d exp=%0d", name, t, i, j, acc[i][j], sum);
                        end
                    end
                vectors++;
                if (!tile_ok) miscompares++;
                t++;
                fs = cyc + 1;
                if (t == tiles) done_cyc = cyc + 1;
            end
            if (done_cyc >= 0 && cyc > done_cyc) begin
                ok = 1;
                break;
            end
        end
        start_i = 1'b0;
        c_ready_i = 1'b0;
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL %s timeout got=no_done exp=done", name);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        vectors++;
        if ({a_addr_o, b_addr_o, c_addr_o, ab_ren_o, a_valid_o, b_valid_o, init_save_o,
             acc_clr_o, c_valid_o, busy_o, done_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%h exp=0", {a_addr_o, b_addr_o, c_addr_o, ab_ren_o,
                     a_valid_o, b_valid_o, init_save_o, acc_clr_o, c_valid_o, busy_o, done_o});
        end
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        vectors++;
        if ({busy_o, done_o, ab_ren_o, c_valid_o} !== 4'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset got=%b exp=0000", {busy_o, done_o, ab_ren_o, c_valid_o});
        end
    endtask

    task automatic test_single();
        run_job(1, 1, 1, 0, -1, "single_111");
    endtask

    task automatic test_gemm_2x2x2();
        run_job(2, 2, 2, 0, -1, "gemm_222");
    endtask

    task automatic test_backpressure();
        run_job(1, 3, 1, 2, -1, "bp_131");
        run_job(2, 1, 3, 2, -1, "bp_213");
    endtask

    task automatic test_zero_dim();
        run_job(2, 2, 0, 0, -1, "zero_n");
        run_job(0, 3, 1, 0, -1, "zero_m");
    endtask

    task automatic test_reset_mid_job();
        @(negedge clk_i);
        m_tiles_i = 2;
        k_tiles_i = 2;
        n_tiles_i = 2;
        start_i = 1'b1;
        c_ready_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        vectors++;
        if ({a_addr_o, b_addr_o, c_addr_o, ab_ren_o, a_valid_o, b_valid_o, init_save_o,
             acc_clr_o, c_valid_o, busy_o, done_o} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs got=%h exp=0", {a_addr_o, b_addr_o, c_addr_o, ab_ren_o,
                     a_valid_o, b_valid_o, init_save_o, acc_clr_o, c_valid_o, busy_o, done_o});
        end
        rst_i = 1'b0;
        c_ready_i = 1'b0;
        run_job(1, 1, 1, 0, -1, "after_reset_111");
    endtask

    task automatic test_restart_ignored();
        run_job(2, 2, 2, 0, 4, "restart_222");
        run_job(2, 3, 2, 1, 9, "restart_rand");
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++)
            run_job($urandom_range(1, 3), $urandom_range(1, 4), $urandom_range(1, 3), 1, -1, "random");
    endtask

    initial begin
        test_reset();
        test_single();
        test_gemm_2x2x2();
        test_backpressure();
        test_zero_dim();
        test_reset_mid_job();
        test_restart_ignored();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
